usbh_report_arbiter: RTL and testbench

Round-robin scheduler that shares one byte-wide display-buffer write port between up to `C_ports` USB HID host instances. It captures each host's `hid_report`/`hid_valid` into a per-port pending slot, serializes the first `C_slot_bytes` bytes of each slot into the buffer, and flags dropped reports. It also tracks per-port activity for the status LEDs. It sits between the `usbh_host_hid` instances and the display/hex-decoder data buffer, all in the `clk_usb` domain.

---
 rtl/usbh_pkg.sv | 18 +
 rtl/usbh_report_slot.sv | 63 ++++++
 rtl/usbh_report_arbiter.sv | 141 ++++++++++++++
 tb/tb_usbh_report_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usbh_pkg.sv
// rtl/usbh_pkg.sv - shared FSM states and width helper for the HID report arbiter
package usbh_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  // Never returns less than 1 so degenerate sizes still get a real bus.
  function automatic int clog2(input int value);
    int w;
    for (w = 1; (1 << w) < value; w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/usbh_report_slot.sv
// rtl/usbh_report_slot.sv - per-port report capture, pending/overrun flags and activity watchdog
module usbh_report_slot
  import usbh_pkg::*;
#(
  parameter int C_slot_bytes     = 8,
  parameter int C_timeout_cycles = 6000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [C_slot_bytes*8-1:0] report,
  input  logic                      valid,
  input  logic                      grant_hit,
  input  logic                      done_clr,
  input  logic                      clr_overrun,
  output logic [C_slot_bytes*8-1:0] data,
  output logic                      pending,
  output logic                      overrun,
  output logic                      active
);

  localparam int            CW    = clog2(C_timeout_cycles + 1);
  localparam logic [CW-1:0] LIMIT = CW'(C_timeout_cycles);

  logic [CW-1:0] count;
  logic          lost;

  // A strobe landing in the completion cycle re-arms the slot; the old report was already sent.
  assign lost = valid && (grant_hit || (pending && !done_clr));

  always_ff @(posedge clk) begin
    if (reset) begin
      data    <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      count   <= LIMIT;
      active  <= 1'b0;
    end else begin
      if (valid && !grant_hit) begin
        data    <= report;
        pending <= 1'b1;
      end else if (done_clr) begin
        pending <= 1'b0;
      end

      if (lost) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end

      if (valid) begin
        count  <= '0;
        active <= 1'b1;
      end else if (count != LIMIT) begin
        count <= count + 1'b1;
        if (count == LIMIT - 1'b1) begin
          active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/usbh_report_arbiter.sv
// rtl/usbh_report_arbiter.sv - round-robin serializer of HID report slots into the display buffer
module usbh_report_arbiter
  import usbh_pkg::*;
#(
  parameter int C_ports          = 3,
  parameter int C_report_bytes   = 20,
  parameter int C_slot_bytes     = 8,
  parameter int C_timeout_cycles = 6000000
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [C_ports*C_report_bytes*8-1:0]   hid_report,
  input  logic [C_ports-1:0]                    hid_valid,
  output logic                                  wr_en,
  input  logic                                  wr_ready,
  output logic [clog2(C_ports*C_slot_bytes)-1:0] wr_addr,
  output logic [7:0]                            wr_data,
  output logic                                  upd_done,
  output logic [1:0]                            upd_port,
  output logic [C_ports-1:0]                    active,
  output logic [C_ports-1:0]                    overrun,
  input  logic                                  clr_overrun
);

  localparam int            AW        = clog2(C_ports * C_slot_bytes);
  localparam int            IW        = clog2(C_slot_bytes);
  localparam logic [IW-1:0] LAST_BEAT = IW'(C_slot_bytes - 1);

  arb_state_t                state, state_nxt;
  logic [1:0]                grant, grant_nxt, last_grant;
  logic [IW-1:0]             idx, idx_nxt;
  logic [C_ports-1:0]        pending;
  logic [C_slot_bytes*8-1:0] slot_data [C_ports];
  logic                      wr_en_nxt, upd_done_nxt;
  logic [AW-1:0]             wr_addr_nxt;
  logic [7:0]                wr_data_nxt;
  logic [1:0]                upd_port_nxt;
  logic                      unused_report;

  // Report bytes beyond the slot are never forwarded.
  assign unused_report = ^hid_report;

  for (genvar i = 0; i < C_ports; i++) begin : g_slot
    usbh_report_slot #(
      .C_slot_bytes    (C_slot_bytes),
      .C_timeout_cycles(C_timeout_cycles)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .report     (hid_report[i*C_report_bytes*8 +: C_slot_bytes*8]),
      .valid      (hid_valid[i]),
      .grant_hit  (state == ST_XFER && grant == 2'(i)),
      .done_clr   (state == ST_DONE && grant == 2'(i)),
      .clr_overrun(clr_overrun),
      .data       (slot_data[i]),
      .pending    (pending[i]),
      .overrun    (overrun[i]),
      .active     (active[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      idx        <= '0;
      last_grant <= 2'(C_ports - 1);
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      upd_done   <= 1'b0;
      upd_port   <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      idx      <= idx_nxt;
      wr_en    <= wr_en_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
      upd_done <= upd_done_nxt;
      upd_port <= upd_port_nxt;
      if (state == ST_DONE) begin
        last_grant <= grant;
      end
    end
  end

  always_comb begin
    int   cand;
    logic found;
    state_nxt = state;
    grant_nxt = grant;
    idx_nxt   = idx;
    cand      = 0;
    found     = 1'b0;
    case (state)
      ST_IDLE: begin
        for (int k = 1; k <= C_ports; k++) begin
          cand = (int'(last_grant) + k) % C_ports;
          if (!found && pending[cand]) begin
            found     = 1'b1;
            grant_nxt = 2'(cand);
          end
        end
        if (found) begin
          state_nxt = ST_XFER;
          idx_nxt   = '0;
        end
      end
      ST_XFER: begin
        if (wr_ready) begin
          idx_nxt = idx + 1'b1;
          if (idx == LAST_BEAT) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A strobe on the edge that grants its own port lands in the slot at that same edge,
  // so the first registered byte is taken straight from the incoming report.
  always_comb begin
    wr_en_nxt    = (state_nxt == ST_XFER);
    wr_addr_nxt  = '0;
    wr_data_nxt  = '0;
    upd_done_nxt = (state_nxt == ST_DONE);
    upd_port_nxt = upd_done_nxt ? grant_nxt : 2'd0;
    if (wr_en_nxt) begin
      wr_addr_nxt = AW'(int'(grant_nxt) * C_slot_bytes + int'(idx_nxt));
      if (state == ST_IDLE && hid_valid[grant_nxt]) begin
        wr_data_nxt = hid_report[int'(grant_nxt)*C_report_bytes*8 +: 8];
      end else begin
        wr_data_nxt = slot_data[grant_nxt][int'(idx_nxt)*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_usbh_report_arbiter.sv
// tb/tb_usbh_report_arbiter.sv - directed and randomized checks of the HID report arbiter
module tb_usbh_report_arbiter;

  localparam int NP = 3;
  localparam int RB = 20;
  localparam int SB = 8;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP*RB*8-1:0] hid_report;
  logic [NP-1:0]    hid_valid;
  logic             wr_en;
  logic             wr_ready;
  logic [4:0]       wr_addr;
  logic [7:0]       wr_data;
  logic             upd_done;
  logic [1:0]       upd_port;
  logic [NP-1:0]    active;
  logic [NP-1:0]    overrun;
  logic             clr_overrun;

  usbh_report_arbiter #(
    .C_ports         (NP),
    .C_report_bytes  (RB),
    .C_slot_bytes    (SB),
    .C_timeout_cycles(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hid_report (hid_report),
    .hid_valid  (hid_valid),
    .wr_en      (wr_en),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .upd_done   (upd_done),
    .upd_port   (upd_port),
    .active     (active),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            addr_q[$];
  int            data_q[$];
  int            done_q[$];
  logic [63:0]   model_slot [NP];
  logic [RB*8-1:0] next_rep [NP];
  int            model_last;
  int            ready_mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en && wr_ready) begin
        addr_q.push_back(int'(wr_addr));
        data_q.push_back(int'(wr_data));
      end
      if (upd_done) done_q.push_back(int'(upd_port));
    end
  end

  function automatic logic [RB*8-1:0] rand_rep();
    logic [RB*8-1:0] r;
    for (int w = 0; w < RB / 4; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic prep(input int p, input logic [RB*8-1:0] r, input bit keep);
    next_rep[p] = r;
    if (keep) model_slot[p] = r[63:0];
  endtask

  task automatic strobe(input logic [NP-1:0] mask);
    for (int p = 0; p < NP; p++)
      if (mask[p]) hid_report[p*RB*8 +: RB*8] = next_rep[p];
    hid_valid = mask;
    tick();
    hid_valid = '0;
  endtask

  function automatic int rr_pick(input int last, input logic [NP-1:0] set);
    for (int k = 1; k <= NP; k++)
      if (set[(last + k) % NP]) return (last + k) % NP;
    return -1;
  endfunction

  task automatic wait_done(input int n, input int budget);
    int         cyc;
    logic       pe, pr;
    logic [4:0] pa;
    logic [7:0] pd;
    cyc = 0;
    while (done_q.size() < n && cyc < budget) begin
      case (ready_mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = ~wr_ready;
        default: wr_ready = 1'($urandom_range(0, 1));
      endcase
      pe = wr_en; pr = wr_ready; pa = wr_addr; pd = wr_data;
      tick();
      cyc++;
      if (pe && !pr) begin
        chk("hold_en", 64'(wr_en), 64'(1));
        chk("hold_addr", 64'(wr_addr), 64'(pa));
        chk("hold_data", 64'(wr_data), 64'(pd));
      end
    end
    chk("done_count", 64'(done_q.size()), 64'(n));
    wr_ready = 1'b1;
  endtask

  task automatic verify_port(input int p);
    if (done_q.size() == 0) chk("upd_missing", 64'(done_q.size()), 64'(1));
    else chk("upd_port", 64'(done_q.pop_front()), 64'(p));
    for (int k = 0; k < SB; k++) begin
      if (addr_q.size() == 0) chk("beat_missing", 64'(addr_q.size()), 64'(1));
      else begin
        chk("wr_addr", 64'(addr_q.pop_front()), 64'(p * SB + k));
        chk("wr_data", 64'(data_q.pop_front()), 64'(model_slot[p][k*8 +: 8]));
      end
    end
    model_last = p;
  endtask

  task automatic clear_ovr();
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [NP-1:0] m1, m2, rem;
    int            order[$];
    int            cur;
    logic [RB*8-1:0] r;

    reset = 1'b1; hid_report = '0; hid_valid = '0; wr_ready = 1'b1;
    clr_overrun = 1'b0; ready_mode = 0; model_last = NP - 1;
    for (int p = 0; p < NP; p++) begin model_slot[p] = '0; next_rep[p] = '0; end
    tick(); tick();
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_upd_done", 64'(upd_done), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_upd_port", 64'(upd_port), 64'(0));
    chk("rst_active", 64'(active), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    reset = 1'b0;

    // single report, exact cycle timing
    r = rand_rep(); r[63:0] = 64'h0807060504030201;
    prep(0, r, 1);
    strobe(3'b001);
    chk("first_not_yet", 64'(wr_en), 64'(0));
    chk("active_rise", 64'(active), 64'(3'b001));
    tick();
    for (int k = 0; k < SB; k++) begin
      chk("single_en", 64'(wr_en), 64'(1));
      chk("single_addr", 64'(wr_addr), 64'(k));
      chk("single_data", 64'(wr_data), 64'(k + 1));
      tick();
    end
    chk("single_upd_done", 64'(upd_done), 64'(1));
    chk("single_upd_port", 64'(upd_port), 64'(0));
    chk("single_en_off", 64'(wr_en), 64'(0));
    tick();
    chk("single_upd_pulse", 64'(upd_done), 64'(0));
    addr_q.delete(); data_q.delete(); done_q.delete();

    // round-robin
    reset = 1'b1; tick(); reset = 1'b0; model_last = NP - 1;
    for (int p = 0; p < NP; p++) prep(p, rand_rep(), 1);
    strobe(3'b111);
    wait_done(3, 200);
    verify_port(0); verify_port(1); verify_port(2);
    prep(1, rand_rep(), 1);
    strobe(3'b010);
    wait_done(1, 100);
    verify_port(1);
    prep(1, rand_rep(), 1); prep(2, rand_rep(), 1);
    strobe(3'b110);
    wait_done(2, 200);
    verify_port(2); verify_port(1);
    chk("rr_extra", 64'(addr_q.size()), 64'(0));

    // backpressure with toggling ready
    ready_mode = 1;
    prep(0, rand_rep(), 1);
    strobe(3'b001);
    wait_done(1, 100);
    verify_port(0);
    chk("bp_extra", 64'(addr_q.size()), 64'(0));
    ready_mode = 0;

    // overwrite of a waiting slot while another port transfers
    prep(0, rand_rep(), 1);
    strobe(3'b001);
    tick();
    prep(1, {RB{8'hAA}}, 0);
    strobe(3'b010);
    chk("ovr_first_none", 64'(overrun), 64'(0));
    prep(1, {RB{8'hBB}}, 1);
    strobe(3'b010);
    chk("ovr_set", 64'(overrun), 64'(3'b010));
    wait_done(2, 200);
    verify_port(0); verify_port(1);
    clear_ovr();
    chk("ovr_clear", 64'(overrun), 64'(0));

    // set coincident with clear: set wins
    prep(2, rand_rep(), 0);
    strobe(3'b100);
    prep(2, rand_rep(), 1);
    clr_overrun = 1'b1;
    strobe(3'b100);
    clr_overrun = 1'b0;
    chk("ovr_set_wins", 64'(overrun), 64'(3'b100));
    wait_done(1, 100);
    verify_port(2);
    clear_ovr();

    // strobe on the port being transferred is dropped
    prep(0, rand_rep(), 1);
    strobe(3'b001);
    tick();
    prep(0, rand_rep(), 0);
    strobe(3'b001);
    chk("drop_ovr", 64'(overrun), 64'(3'b001));
    wait_done(1, 100);
    verify_port(0);
    repeat (12) tick();
    chk("drop_no_second", 64'(done_q.size()), 64'(0));
    clear_ovr();

    // watchdog, with the transfer stalled by backpressure
    repeat (20) tick();
    chk("wd_idle", 64'(active), 64'(0));
    wr_ready = 1'b0;
    prep(2, rand_rep(), 1);
    strobe(3'b100);
    chk("wd_rise", 64'(active[2]), 64'(1));
    repeat (9) tick();
    chk("wd_stall_en", 64'(wr_en), 64'(1));
    chk("wd_stall_addr", 64'(wr_addr), 64'(2 * SB));
    chk("wd_stall_data", 64'(wr_data), 64'(model_slot[2][7:0]));
    prep(2, rand_rep(), 0);
    strobe(3'b100);
    chk("wd_drop_ovr", 64'(overrun[2]), 64'(1));
    repeat (6) tick();
    chk("wd_extended", 64'(active[2]), 64'(1));
    repeat (9) tick();
    chk("wd_last_high", 64'(active[2]), 64'(1));
    tick();
    chk("wd_fall", 64'(active[2]), 64'(0));
    wait_done(1, 100);
    verify_port(2);
    clear_ovr();

    // reset in the middle of a transfer
    prep(1, rand_rep(), 1);
    strobe(3'b010);
    repeat (4) tick();
    chk("mid_beat3", 64'(wr_addr), 64'(SB + 3));
    reset = 1'b1;
    tick();
    chk("mid_wr_en", 64'(wr_en), 64'(0));
    chk("mid_upd_done", 64'(upd_done), 64'(0));
    chk("mid_active", 64'(active), 64'(0));
    reset = 1'b0;
    model_last = NP - 1;
    chk("mid_beats", 64'(addr_q.size()), 64'(3));
    addr_q.delete(); data_q.delete();
    repeat (12) tick();
    chk("mid_no_done", 64'(done_q.size()), 64'(0));
    chk("mid_no_beats", 64'(addr_q.size()), 64'(0));
    prep(1, rand_rep(), 1);
    strobe(3'b010);
    wait_done(1, 100);
    verify_port(1);

    // randomized rounds against the round-robin model
    for (int rnd = 0; rnd < 25; rnd++) begin
      m1 = 3'($urandom_range(1, 7));
      m2 = 3'($urandom_range(0, 7));
      ready_mode = $urandom_range(0, 2);
      for (int p = 0; p < NP; p++) if (m1[p]) prep(p, rand_rep(), 1);
      strobe(m1);
      for (int p = 0; p < NP; p++) if (m2[p]) prep(p, rand_rep(), 1);
      strobe(m2);
      chk("rnd_overrun", 64'(overrun), 64'(m1 & m2));
      order.delete();
      cur = rr_pick(model_last, m1);
      order.push_back(cur);
      rem = (m1 | m2) & ~(NP'(1) << cur);
      while (rem != '0) begin
        cur = rr_pick(cur, rem);
        order.push_back(cur);
        rem[cur] = 1'b0;
      end
      wait_done(order.size(), 400);
      foreach (order[i]) verify_port(order[i]);
      chk("rnd_extra", 64'(addr_q.size()), 64'(0));
      clear_ovr();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
